fir_pe_collector: RTL and testbench
===================================

// Module: fir_pe_collector
// PURPOSE
//  Receiving end of the FIR_PE systolic-array nibble stream. Sits after the last
//  FIR_PE stage: samples Vld/Xout/Yout, reassembles nibble-serial X and Y words
//  (LS nibble first), buffers them in a small FIFO, and presents them on a
//  valid/ready interface to the host or the SystemC co-simulation bridge.
// PARAMETERS
//  NIB_W         4  nibble width of the Xout/Yout lanes
//  NIB_PER_WORD  4  nibbles per word; word width WORD_W = NIB_W*NIB_PER_WORD
//  FIFO_DEPTH    4  word-pair FIFO entries (power of 2, >=2)
//  CNT_W         8  width of the received-word counter
// PORTS
//  clk        in   1       system clock, rising edge
//  nReset     in   1       asynchronous active-low reset
//  Vld        in   1       nibble-valid from the last FIR_PE (its Vld output)
//  Xin        in   NIB_W   Xout nibble of the last FIR_PE
//  Yin        in   NIB_W   Yout nibble of the last FIR_PE
//  clear      in   1       sync: flush FIFO and assembler, clear flags and counter
//  m_valid    out  1       word pair available at the head of the FIFO
//  m_ready    in   1       consumer accepts the head when m_valid & m_ready
//  m_x        out  WORD_W  reassembled X word (raw bits)
//  m_y        out  WORD_W  reassembled Y word (two's-complement raw bits)
//  overflow   out  1       sticky: a completed word was dropped because the FIFO was full
//  frame_err  out  1       1-cycle pulse: Vld fell before a word completed
//  word_cnt   out  CNT_W   completed words pushed to the FIFO, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset values (nReset low, async): m_valid=0, m_x=0, m_y=0, overflow=0,
//    frame_err=0, word_cnt=0, FIFO empty, FSM in IDLE, nibble index=0.
//  - Framing: one word = NIB_PER_WORD consecutive cycles with Vld=1; each Vld=1
//    cycle carries nibble k (k=0 is the LSB) on Xin and Yin together.
//  - FSM states and transitions:
//      IDLE  -> SHIFT on Vld=1; captures nibble 0 and sets idx=1.
//      SHIFT, Vld=1, idx<NIB_PER_WORD-1: capture nibble idx; idx++.
//      SHIFT, Vld=1, idx=NIB_PER_WORD-1: word complete. {nibble, shift reg} is
//        pushed on this edge; next state is IDLE and idx=0.
//      SHIFT, Vld=0: frame_err pulses on the next cycle, partial word is
//        discarded, next state is IDLE.
//  - Back-to-back words: Vld held high across word boundaries is legal. The
//    nibble after a completion is nibble 0 of the next word, with no bubble.
//  - Push latency: m_valid rises one cycle after the edge that samples the last
//    nibble, when the FIFO was empty. m_x/m_y come from registers and are stable
//    while m_valid=1 and m_ready=0.
//  - FIFO full on push: word dropped, overflow set, word_cnt unchanged.
//  - Full with simultaneous push and pop: the pop frees a slot, so the push is
//    accepted and overflow stays unchanged.
//  - Empty with simultaneous push and pop: no pop, because m_valid=0. The push
//    is accepted.
//  - clear has priority over all activity in that cycle. The FIFO is emptied,
//    m_valid drops next cycle, FSM goes to IDLE, overflow=0, word_cnt=0, and no
//    frame_err is raised.
//  - Reset mid-word or mid-FIFO: all state is lost, with no partial output.
//    After release the first Vld=1 is nibble 0.
//  - The Xin/Yin lanes are ignored while Vld=0.
// STRUCTURE
//  - fir_pe_pkg holds the constants and types: NIB_W, NIB_PER_WORD, WORD_W, the
//    FSM state enum {IDLE, SHIFT}, and the word-pair struct {x, y}.
//  - Sub-module fir_pe_sync_fifo (WIDTH=2*WORD_W, DEPTH) contains pointers, a
//    count, full/empty flags, and registered head output.
//  - The top level contains the FSM, the nibble index, shift registers,
//    overflow/frame_err logic, and word_cnt.
// TESTING
//  1. Single word: Vld=1 for 4 cycles with Yin=1,2,3,4 and Xin=F,E,D,C.
//     Expect m_y=16'h4321, m_x=16'hCDEF, m_valid one cycle after the 4th
//     nibble, word_cnt=1.
//  2. Streaming: Vld held high for 12 cycles (3 words), m_ready=1. Expect 3
//     words in order, no gaps, word_cnt=3, overflow=0.
//  3. Truncated frame: Vld=1 for 2 cycles, then 0. Expect a frame_err pulse,
//     no push, and the next full word decoded correctly.
//  4. Overflow: m_ready=0 while 5 words are sent. Expect 4 buffered words,
//     overflow=1, word_cnt=4. Drain with m_ready=1 and expect the first 4 words
//     intact.
//  5. Full + simultaneous push/pop: FIFO full, last nibble coincides with
//     m_ready=1. Expect the push accepted, overflow=0, count still 4.
//  6. Async reset mid-word (after nibble 2), then clear with 2 words queued.
//     Expect all outputs at reset values, the next word decoded from nibble 0,
//     and m_valid=0 the cycle after clear.

Source files
------------

// File: rtl/fir_pe_pkg.sv
// Shared constants and types for the FIR_PE nibble-stream collector.
// Word geometry, assembler FSM encoding and the buffered word-pair layout.
package fir_pe_pkg;

    localparam int unsigned NIB_W        = 4;
    localparam int unsigned NIB_PER_WORD = 4;
    localparam int unsigned WORD_W       = NIB_W * NIB_PER_WORD;
    localparam int unsigned IDX_W        = $clog2(NIB_PER_WORD);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] x;
        logic [WORD_W-1:0] y;
    } word_pair_t;

endpackage

// File: rtl/fir_pe_sync_fifo.sv
// Synchronous FIFO with a registered head word; a push is accepted when full
// only if a pop frees a slot in the same cycle.
module fir_pe_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             accept_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        // Head register pre-loads the next entry; write-through when the
        // slot about to become the head is being written this cycle.
        if (count_d == '0) begin
            head_d = head_q;
        end else if (do_push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        valid_d = (count_d != '0);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_i && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign accept_o = do_push && !clear_i;
    assign valid_o  = valid_q;
    assign data_o   = head_q;

endmodule

// File: rtl/fir_pe_collector.sv
// Collector at the tail of the FIR_PE array: reassembles LS-nibble-first X/Y
// words and buffers them for a valid/ready consumer.
module fir_pe_collector
    import fir_pe_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              Vld,
    input  logic [NIB_W-1:0]  Xin,
    input  logic [NIB_W-1:0]  Yin,
    input  logic              clear,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_x,
    output logic [WORD_W-1:0] m_y,
    output logic              overflow,
    output logic              frame_err,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int unsigned SH_W = WORD_W - NIB_W;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SH_W-1:0]  xsh_q, xsh_d;
    logic [SH_W-1:0]  ysh_q, ysh_d;
    logic             ovf_q, ovf_d;
    logic             ferr_q, ferr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_req;
    logic             fifo_accept;
    word_pair_t       push_pair, head_pair;

    // Earlier nibbles sit in the shift registers LS-first; the final nibble
    // is taken straight from the lanes on the completing edge.
    assign push_pair.x = {Xin, xsh_q};
    assign push_pair.y = {Yin, ysh_q};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xsh_d    = xsh_q;
        ysh_d    = ysh_q;
        ferr_d   = 1'b0;
        push_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (Vld) begin
                    state_d = SHIFT;
                    idx_d   = IDX_W'(1);
                    xsh_d   = {Xin, xsh_q[SH_W-1:NIB_W]};
                    ysh_d   = {Yin, ysh_q[SH_W-1:NIB_W]};
                end
            end
            SHIFT: begin
                if (!Vld) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    ferr_d  = 1'b1;
                end else if (idx_q == IDX_W'(NIB_PER_WORD - 1)) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    push_req = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    xsh_d = {Xin, xsh_q[SH_W-1:NIB_W]};
                    ysh_d = {Yin, ysh_q[SH_W-1:NIB_W]};
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        if (clear) begin
            state_d  = IDLE;
            idx_d    = '0;
            ferr_d   = 1'b0;
            push_req = 1'b0;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (push_req && !fifo_accept) begin
            ovf_d = 1'b1;
        end
        if (fifo_accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (clear) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            xsh_q   <= '0;
            ysh_q   <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            xsh_q   <= xsh_d;
            ysh_q   <= ysh_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
            cnt_q   <= cnt_d;
        end
    end

    fir_pe_sync_fifo #(
        .WIDTH (2 * WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .nReset   (nReset),
        .clear_i  (clear),
        .push_i   (push_req),
        .pop_i    (m_ready),
        .data_i   (push_pair),
        .accept_o (fifo_accept),
        .valid_o  (m_valid),
        .data_o   (head_pair)
    );

    assign m_x       = head_pair.x;
    assign m_y       = head_pair.y;
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_fir_pe_collector.sv
// Scoreboard bench for fir_pe_collector: stimulus queues expected word pairs,
// a negedge monitor pops and compares every accepted output.
module tb_fir_pe_collector;

    logic        clk = 1'b0;
    logic        nReset;
    logic        Vld;
    logic [3:0]  Xin, Yin;
    logic        clear;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_x, m_y;
    logic        overflow;
    logic        frame_err;
    logic [7:0]  word_cnt;

    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic [31:0] sb [$];

    fir_pe_collector #(
        .FIFO_DEPTH (4),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .Vld       (Vld),
        .Xin       (Xin),
        .Yin       (Yin),
        .clear     (clear),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_x       (m_x),
        .m_y       (m_y),
        .overflow  (overflow),
        .frame_err (frame_err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (nReset && m_valid && m_ready) begin
            logic [31:0] exp_pair;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got x=%h y=%h, required no output", m_x, m_y);
            end else begin
                exp_pair = sb.pop_front();
                if ({m_x, m_y} !== exp_pair) begin
                    errors++;
                    $display("FAIL pop_data: got x=%h y=%h, required x=%h y=%h",
                             m_x, m_y, exp_pair[31:16], exp_pair[15:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] x, input logic [15:0] y, input bit exp_push);
        if (exp_push) begin
            sb.push_back({x, y});
            exp_cnt++;
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            Vld = 1'b1;
            Xin = x[k*4 +: 4];
            Yin = y[k*4 +: 4];
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        Vld = 1'b0;
        Xin = 4'($urandom);
        Yin = 4'($urandom);
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && m_valid; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_m_valid_low"}, m_valid, 0);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_m_valid"}, m_valid, 0);
        check({name, "_m_x"}, m_x, 0);
        check({name, "_m_y"}, m_y, 0);
        check({name, "_overflow"}, overflow, 0);
        check({name, "_frame_err"}, frame_err, 0);
        check({name, "_word_cnt"}, word_cnt, 0);
    endtask

    initial begin
        nReset  = 1'b0;
        Vld     = 1'b0;
        Xin     = '0;
        Yin     = '0;
        clear   = 1'b0;
        m_ready = 1'b0;
        #12;
        check_reset_values("reset");
        @(posedge clk); #1;
        nReset = 1'b1;

        // 1: single word
        m_ready = 1'b1;
        send_word(16'hCDEF, 16'h4321, 1);
        idle();
        check("t1_m_valid", m_valid, 1);
        check("t1_m_x", m_x, 16'hCDEF);
        check("t1_m_y", m_y, 16'h4321);
        check("t1_word_cnt", word_cnt, 1);
        drain("t1");

        // 2: three back-to-back words
        send_word(16'h1234, 16'hA5A5, 1);
        send_word(16'h5678, 16'h0001, 1);
        send_word(16'h9ABC, 16'hFFFF, 1);
        idle();
        check("t2_word_cnt", word_cnt, 4);
        check("t2_overflow", overflow, 0);
        drain("t2");

        // 3: truncated frame then a good word
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            Vld = 1'b1;
            Xin = 4'(k + 7);
            Yin = 4'(k + 3);
        end
        idle();
        @(posedge clk); #1;
        check("t3_frame_err_pulse", frame_err, 1);
        check("t3_no_push_valid", m_valid, 0);
        check("t3_no_push_cnt", word_cnt, 4);
        @(posedge clk); #1;
        check("t3_frame_err_drop", frame_err, 0);
        send_word(16'h8001, 16'h7FFE, 1);
        idle();
        check("t3_word_cnt", word_cnt, 5);
        drain("t3");

        // 4: overflow with consumer stalled
        m_ready = 1'b0;
        send_word(16'h1111, 16'h0101, 1);
        send_word(16'h2222, 16'h0202, 1);
        send_word(16'h3333, 16'h0303, 1);
        send_word(16'h4444, 16'h0404, 1);
        send_word(16'h5555, 16'h0505, 0);
        idle();
        check("t4_overflow", overflow, 1);
        check("t4_word_cnt", word_cnt, 9);
        check("t4_head_x", m_x, 16'h1111);
        check("t4_head_y", m_y, 16'h0101);
        drain("t4");
        check("t4_overflow_sticky", overflow, 1);

        // 5: clear, refill, then push coinciding with pop while full
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_cnt = 0;
        check("t5_clear_overflow", overflow, 0);
        check("t5_clear_word_cnt", word_cnt, 0);
        m_ready = 1'b0;
        send_word(16'hA001, 16'hB001, 1);
        send_word(16'hA002, 16'hB002, 1);
        send_word(16'hA003, 16'hB003, 1);
        send_word(16'hA004, 16'hB004, 1);
        sb.push_back({16'hA005, 16'hB005});
        for (int k = 0; k < 4; k++) begin
            logic [15:0] xw, yw;
            xw = 16'hA005;
            yw = 16'hB005;
            @(posedge clk); #1;
            Vld = 1'b1;
            Xin = xw[k*4 +: 4];
            Yin = yw[k*4 +: 4];
            if (k == 3) m_ready = 1'b1;
        end
        @(posedge clk); #1;
        m_ready = 1'b0;
        Vld     = 1'b0;
        check("t5_overflow", overflow, 0);
        check("t5_word_cnt", word_cnt, 5);
        check("t5_m_valid", m_valid, 1);
        check("t5_head_x", m_x, 16'hA002);
        drain("t5");

        // 6: async reset mid-word with a word queued
        m_ready = 1'b0;
        send_word(16'h1357, 16'h2468, 1);
        idle();
        check("t6_queued_valid", m_valid, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            Vld = 1'b1;
            Xin = 4'(k + 9);
            Yin = 4'(k + 1);
        end
        @(posedge clk); #3;
        nReset = 1'b0;
        Vld    = 1'b0;
        sb.delete();
        exp_cnt = 0;
        #1;
        check_reset_values("t6_async");
        @(negedge clk);
        nReset  = 1'b1;
        m_ready = 1'b1;
        send_word(16'h0F0F, 16'hF0F0, 1);
        idle();
        check("t6_after_reset_x", m_x, 16'h0F0F);
        check("t6_after_reset_y", m_y, 16'hF0F0);
        check("t6_after_reset_cnt", word_cnt, 1);
        drain("t6a");

        // 6b: clear with two words queued
        m_ready = 1'b0;
        send_word(16'hDEAD, 16'hBEEF, 1);
        send_word(16'hCAFE, 16'hF00D, 1);
        idle();
        check("t6_two_queued_valid", m_valid, 1);
        check("t6_two_queued_cnt", word_cnt, 3);
        @(posedge clk); #1;
        clear = 1'b1;
        sb.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        clear = 1'b0;
        check("t6_clear_m_valid", m_valid, 0);
        check("t6_clear_word_cnt", word_cnt, 0);
        check("t6_clear_overflow", overflow, 0);
        check("t6_clear_frame_err", frame_err, 0);
        @(posedge clk); #1;
        check("t6_clear_m_valid_hold", m_valid, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
